// File: rtl/ivl_uvm_ovl_collector_pkg.sv
// Package: ivl_uvm_ovl_collector_pkg
// Purpose: shared constants and types for the OVL fire collector.
//   FIRE_*   : layout of one checker's 3-bit fire vector
//   rpt_t    : one queued report {chk_id, rpt_type, ts} at the default widths
//   id_width : width of a checker index (never narrower than 1 bit)
package ivl_uvm_ovl_collector_pkg;

  localparam int FIRE_W      = 3;
  localparam int FIRE_ASSERT = 0;
  localparam int FIRE_XZ     = 1;
  localparam int FIRE_COVER  = 2;

  localparam int RPT_ID_W = 2;
  localparam int RPT_TS_W = 32;

  typedef struct packed {
    logic [RPT_ID_W-1:0] chk_id;
    logic [1:0]          rpt_type;
    logic [RPT_TS_W-1:0] ts;
  } rpt_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ivl_uvm_ovl_sync_fifo.sv
// Module: ivl_uvm_ovl_sync_fifo
// Purpose: synchronous report queue with first-word-fall-through head.
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   clear            : synchronous flush (wins over push/pop)
//   push, push_data  : write request and data; accepted when not full or when popping
//   pop              : read request; ignored when empty
//   pop_data         : current head entry
//   full, empty      : occupancy flags
module ivl_uvm_ovl_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push into a full queue is legal when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// Module: ivl_uvm_ovl_fire_collector
// Purpose: collects the 3-bit fire outputs of NUM_CHK OVL checkers, keeps a
//   saturating failure count per checker, captures the first failure and
//   queues one timestamped report per failing checker event.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   enable                : fires are sampled only while high
//   clear                 : synchronous clear of counters, first-fail, overflow, pending, queue
//   fire_in               : checker k at [3k+2:3k] = {cover, xz, assert}
//   rpt_valid/rpt_ready   : report handshake
//   rpt_chk_id/type/ts    : head report (zero while no report is valid)
//   fail_cnt              : per-checker counters, checker k at [CNT_W*k +: CNT_W]
//   any_fail              : some counter is non-zero
//   first_valid/id/ts     : first failure since reset or clear
//   overflow              : sticky, an event merged into a still-pending entry
module ivl_uvm_ovl_fire_collector
  import ivl_uvm_ovl_collector_pkg::*;
#(
  parameter int  NUM_CHK    = 4,
  parameter int  CNT_W      = 16,
  parameter int  TS_W       = 32,
  parameter int  FIFO_DEPTH = 8,
  localparam int ID_W       = id_width(NUM_CHK)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [NUM_CHK*FIRE_W-1:0] fire_in,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [ID_W-1:0]           rpt_chk_id,
  output logic [1:0]                rpt_type,
  output logic [TS_W-1:0]           rpt_ts,
  output logic [NUM_CHK*CNT_W-1:0]  fail_cnt,
  output logic                      any_fail,
  output logic                      first_valid,
  output logic [ID_W-1:0]           first_id,
  output logic [TS_W-1:0]           first_ts,
  output logic                      overflow
);

  typedef struct packed {
    logic [ID_W-1:0] chk_id;
    logic [1:0]      rpt_type;
    logic [TS_W-1:0] ts;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [TS_W-1:0]    ts;
  logic [NUM_CHK-1:0] ev;
  logic [1:0]         ev_type [NUM_CHK];
  logic [NUM_CHK-1:0] cover_bits;
  logic               unused_cover;

  logic [CNT_W-1:0]   cnt [NUM_CHK];
  logic [ID_W-1:0]    lowest_ev_id;

  logic [NUM_CHK-1:0] pend_valid;
  logic [1:0]         pend_type [NUM_CHK];
  logic [TS_W-1:0]    pend_ts   [NUM_CHK];
  logic [ID_W-1:0]    rr_ptr;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  entry_t             push_entry;
  entry_t             head;
  logic [ENTRY_W-1:0] head_bits;

  // Event decode. Cover bits never produce events; clear discards the cycle's events.
  always_comb begin
    ev         = '0;
    cover_bits = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      ev_type[k]    = {fire_in[FIRE_W*k+FIRE_XZ], fire_in[FIRE_W*k+FIRE_ASSERT]};
      ev[k]         = enable & ~clear & (|ev_type[k]);
      cover_bits[k] = fire_in[FIRE_W*k+FIRE_COVER];
    end
  end

  assign unused_cover = ^cover_bits;

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // Saturating per-checker counters; any_fail stays set until clear since counters never wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CHK; k++) cnt[k] <= '0;
      any_fail <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < NUM_CHK; k++) cnt[k] <= '0;
      any_fail <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CHK; k++) begin
        if (ev[k] && (cnt[k] != {CNT_W{1'b1}})) cnt[k] <= cnt[k] + 1'b1;
      end
      if (|ev) any_fail <= 1'b1;
    end
  end

  always_comb begin
    fail_cnt = '0;
    for (int k = 0; k < NUM_CHK; k++) fail_cnt[CNT_W*k +: CNT_W] = cnt[k];
  end

  // Lowest-index simultaneous event wins the first-fail capture.
  always_comb begin
    lowest_ev_id = '0;
    for (int k = NUM_CHK - 1; k >= 0; k--) begin
      if (ev[k]) lowest_ev_id = ID_W'(k);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_valid <= 1'b0;
      first_id    <= '0;
      first_ts    <= '0;
    end else if (clear) begin
      first_valid <= 1'b0;
      first_id    <= '0;
      first_ts    <= '0;
    end else if (!first_valid && (|ev)) begin
      first_valid <= 1'b1;
      first_id    <= lowest_ev_id;
      first_ts    <= ts;
    end
  end

  // Round-robin: first valid slot at or after the pointer, otherwise wrap to the lowest one.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      if (!grant_valid && pend_valid[k] && (ID_W'(k) >= rr_ptr)) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(k);
      end
    end
    for (int k = 0; k < NUM_CHK; k++) begin
      if (!grant_valid && pend_valid[k]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(k);
      end
    end
  end

  assign pop  = rpt_valid & rpt_ready;
  assign push = grant_valid & (~fifo_full | pop) & ~clear;

  always_comb begin
    push_entry          = '0;
    push_entry.chk_id   = grant_id;
    push_entry.rpt_type = pend_type[grant_id];
    push_entry.ts       = pend_ts[grant_id];
  end

  // Pending slots: a granted slot is freed (or reloaded by a same-cycle event);
  // an occupied, ungranted slot absorbs new events and flags overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_valid <= '0;
      for (int k = 0; k < NUM_CHK; k++) begin
        pend_type[k] <= '0;
        pend_ts[k]   <= '0;
      end
      overflow <= 1'b0;
      rr_ptr   <= '0;
    end else if (clear) begin
      pend_valid <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) rr_ptr <= (grant_id == ID_W'(NUM_CHK - 1)) ? '0 : grant_id + 1'b1;
      for (int k = 0; k < NUM_CHK; k++) begin
        if (push && (grant_id == ID_W'(k))) begin
          pend_valid[k] <= ev[k];
          pend_type[k]  <= ev_type[k];
          pend_ts[k]    <= ts;
        end else if (ev[k]) begin
          if (pend_valid[k]) begin
            pend_type[k] <= pend_type[k] | ev_type[k];
            overflow     <= 1'b1;
          end else begin
            pend_valid[k] <= 1'b1;
            pend_type[k]  <= ev_type[k];
            pend_ts[k]    <= ts;
          end
        end
      end
    end
  end

  ivl_uvm_ovl_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head      = head_bits;
  assign rpt_valid = ~fifo_empty;
  // Report fields read as zero when nothing is queued so reset leaves every output at 0.
  assign rpt_chk_id = rpt_valid ? head.chk_id   : '0;
  assign rpt_type   = rpt_valid ? head.rpt_type : '0;
  assign rpt_ts     = rpt_valid ? head.ts       : '0;

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
// Testbench: tb_ivl_uvm_ovl_fire_collector
// Purpose: directed scenarios for the fire collector. Expected reports are
//   queued when fires are driven; an independent monitor pops and compares
//   every accepted report. Status outputs are compared directly.
module tb_ivl_uvm_ovl_fire_collector;
  import ivl_uvm_ovl_collector_pkg::*;

  localparam int NUM_CHK    = 4;
  localparam int CNT_W      = 4;
  localparam int TS_W       = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int ID_W       = 2;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable = 1'b0;
  logic                     clear = 1'b0;
  logic [NUM_CHK*3-1:0]     fire_in = '0;
  logic                     rpt_valid;
  logic                     rpt_ready = 1'b0;
  logic [ID_W-1:0]          rpt_chk_id;
  logic [1:0]               rpt_type;
  logic [TS_W-1:0]          rpt_ts;
  logic [NUM_CHK*CNT_W-1:0] fail_cnt;
  logic                     any_fail;
  logic                     first_valid;
  logic [ID_W-1:0]          first_id;
  logic [TS_W-1:0]          first_ts;
  logic                     overflow;

  int          tests_run = 0;
  int          tests_failed = 0;
  rpt_t        exp_q[$];
  rpt_t        mon_exp;
  logic [31:0] tb_ts;
  logic [31:0] saved_ts;

  ivl_uvm_ovl_fire_collector #(
    .NUM_CHK    (NUM_CHK),
    .CNT_W      (CNT_W),
    .TS_W       (TS_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .fire_in     (fire_in),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_chk_id  (rpt_chk_id),
    .rpt_type    (rpt_type),
    .rpt_ts      (rpt_ts),
    .fail_cnt    (fail_cnt),
    .any_fail    (any_fail),
    .first_valid (first_valid),
    .first_id    (first_id),
    .first_ts    (first_ts),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  // Cycle counter: the timestamp a fire driven in the current cycle must carry.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1;
  end

  // Monitor: every accepted report must match the oldest expected one.
  always @(negedge clock) begin
    if (!reset && rpt_valid && rpt_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_report: got id=%0d type=%b ts=%0d, none required",
                 rpt_chk_id, rpt_type, rpt_ts);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rpt_chk_id !== mon_exp.chk_id || rpt_type !== mon_exp.rpt_type || rpt_ts !== mon_exp.ts) begin
          tests_failed++;
          $display("[TB] FAIL report: got id=%0d type=%b ts=%0d, required id=%0d type=%b ts=%0d",
                   rpt_chk_id, rpt_type, rpt_ts, mon_exp.chk_id, mon_exp.rpt_type, mon_exp.ts);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    tests_run++;
    if (actual !== required) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Drive one cycle of fires and queue the reports they must produce.
  task automatic applyStimulus(input logic [NUM_CHK*3-1:0] fire, input logic en, input bit expect_rpt);
    rpt_t r;
    fire_in = fire;
    enable  = en;
    if (expect_rpt && en && !clear) begin
      for (int k = 0; k < NUM_CHK; k++) begin
        if (fire[3*k] || fire[3*k+1]) begin
          r.chk_id   = ID_W'(k);
          r.rpt_type = {fire[3*k+1], fire[3*k]};
          r.ts       = tb_ts;
          exp_q.push_back(r);
        end
      end
    end
    tick();
    fire_in = '0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: %0d reports still outstanding, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    rpt_t r;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_rpt_valid", rpt_valid, 0);
    checkOutput("reset_fail_cnt", fail_cnt, 0);
    checkOutput("reset_any_fail", any_fail, 0);
    checkOutput("reset_first_valid", first_valid, 0);
    checkOutput("reset_overflow", overflow, 0);

    // 1. Single fire at ts=5, report at ts=7
    reset = 1'b0;
    enable = 1'b1;
    rpt_ready = 1'b1;
    idle(5);
    applyStimulus(12'h001, 1'b1, 1'b1);
    checkOutput("t1_valid_at_ts6", rpt_valid, 0);
    checkOutput("t1_fail_cnt0", fail_cnt[3:0], 1);
    checkOutput("t1_any_fail", any_fail, 1);
    checkOutput("t1_first_valid", first_valid, 1);
    checkOutput("t1_first_id", first_id, 0);
    checkOutput("t1_first_ts", first_ts, 5);
    tick();
    checkOutput("t1_valid_at_ts7", rpt_valid, 1);
    waitDrain("t1_drain", 10);

    // 2. Simultaneous xz fires on checkers 1 and 3
    doClear();
    checkOutput("t2_first_cleared", first_valid, 0);
    saved_ts = tb_ts;
    applyStimulus(12'h410, 1'b1, 1'b1);
    checkOutput("t2_first_id", first_id, 1);
    checkOutput("t2_first_ts", first_ts, saved_ts);
    waitDrain("t2_drain", 20);

    // 3. Backpressure: 8 queued, 9th pending, 10th merged
    rpt_ready = 1'b0;
    doClear();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(12'h001, 1'b1, 1'b1);
      idle(1);
    end
    checkOutput("t3_no_overflow_yet", overflow, 0);
    applyStimulus(12'h002, 1'b1, 1'b0);
    r = exp_q.pop_back();
    r.rpt_type = r.rpt_type | 2'b10;
    exp_q.push_back(r);
    checkOutput("t3_overflow", overflow, 1);
    checkOutput("t3_fail_cnt0", fail_cnt[3:0], 10);
    checkOutput("t3_valid_held", rpt_valid, 1);
    rpt_ready = 1'b1;
    waitDrain("t3_drain", 40);

    // 4. Cover-only fires and disabled fires are ignored
    applyStimulus(12'h924, 1'b1, 1'b1);
    applyStimulus(12'hFFF, 1'b0, 1'b1);
    enable = 1'b1;
    idle(4);
    checkOutput("t4_fail_cnt", fail_cnt, 16'h000A);

    // 5. Saturation of checker 2 at 15
    for (int i = 0; i < 20; i++) applyStimulus(12'h040, 1'b1, 1'b1);
    checkOutput("t5_fail_cnt2", fail_cnt[11:8], 15);
    idle(3);
    checkOutput("t5_fail_cnt2_hold", fail_cnt[11:8], 15);
    waitDrain("t5_drain", 40);

    // 6a. Clear with a fire in the same cycle and a non-empty queue
    rpt_ready = 1'b0;
    applyStimulus(12'h008, 1'b1, 1'b1);
    idle(1);
    applyStimulus(12'h008, 1'b1, 1'b1);
    idle(3);
    checkOutput("t6_queue_nonempty", rpt_valid, 1);
    clear = 1'b1;
    applyStimulus(12'h200, 1'b1, 1'b0);
    clear = 1'b0;
    exp_q.delete();
    checkOutput("t6_clear_fail_cnt", fail_cnt, 0);
    checkOutput("t6_clear_rpt_valid", rpt_valid, 0);
    checkOutput("t6_clear_first_valid", first_valid, 0);
    checkOutput("t6_clear_any_fail", any_fail, 0);
    checkOutput("t6_clear_overflow", overflow, 0);
    rpt_ready = 1'b1;
    idle(5);

    // 6b. Reset mid-burst clears outputs asynchronously
    rpt_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(12'h001, 1'b1, 1'b1);
    checkOutput("t6_pre_reset_valid", rpt_valid, 1);
    fire_in = 12'h001;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_reset_rpt_valid", rpt_valid, 0);
    checkOutput("t6_reset_rpt_fields", {rpt_chk_id, rpt_type, rpt_ts}, 0);
    checkOutput("t6_reset_fail_cnt", fail_cnt, 0);
    checkOutput("t6_reset_any_fail", any_fail, 0);
    checkOutput("t6_reset_first", {first_valid, first_id, first_ts}, 0);
    checkOutput("t6_reset_overflow", overflow, 0);
    exp_q.delete();
    fire_in = '0;
    tick();
    reset = 1'b0;
    rpt_ready = 1'b1;
    idle(5);

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL leftover_reports: got %0d outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
